// File: rtl/hist_pkg.sv
// hist_pkg: shared definitions for the 2D I/Q histogram block.
//   hist_state_e    - controller states
//   HIST_OOR_IDX    - out-of-range bin index for the default 6-bit geometry
//   hist_ram_depth  - counter RAM depth for a given bin-index width
package hist_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    SEARCH,
    OUT_STREAM,
    ACCUM_RD,
    ACCUM_WR,
    DUMP_RD,
    DUMP_OUT
  } hist_state_e;

  localparam int unsigned HIST_BIN_BITS_DEF = 6;

  // All-ones index marks an out-of-range sample on an axis.
  localparam logic [HIST_BIN_BITS_DEF-1:0] HIST_OOR_IDX = '1;

  function automatic int unsigned hist_ram_depth(input int unsigned bin_bits);
    return 32'd1 << (2 * bin_bits);
  endfunction

  localparam int unsigned HIST_RAM_DEPTH = hist_ram_depth(HIST_BIN_BITS_DEF);

endpackage

// File: rtl/axis_bin_search.sv
// axis_bin_search: fixed-latency successive-approximation binner for one axis.
// A start pulse latches the sample; the index is resolved MSB first over
// BIN_BITS cycles. done_o is high during the final search cycle, so idx_o and
// oor_o are valid from the following cycle until the next start.
//   clk_i, rst_i   clock, asynchronous active-high reset
//   start_i        latch val_i and begin a search
//   val_i          signed sample
//   bin_num_i      number of bins (1..2^BIN_BITS-1)
//   width_i        unsigned bin width
//   min_i          signed origin of bin 0
//   done_o         last search step in progress
//   idx_o          bin index, all-ones when out of range
//   oor_o          sample outside [min, min+bin_num*width)
module axis_bin_search
  import hist_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BIN_BITS = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [DATA_W-1:0]   val_i,
  input  logic [BIN_BITS-1:0] bin_num_i,
  input  logic [15:0]         width_i,
  input  logic [15:0]         min_i,
  output logic                done_o,
  output logic [BIN_BITS-1:0] idx_o,
  output logic                oor_o
);

  localparam int unsigned AW = DATA_W + BIN_BITS + 2;
  localparam int unsigned PW = BIN_BITS + 16;

  typedef logic signed [AW-1:0] acc_t;

  acc_t                val_q;
  acc_t                val_ext;
  logic [BIN_BITS-1:0] cur_q, cur_d;
  logic [BIN_BITS-1:0] bit_q;
  logic [BIN_BITS-1:0] trial;
  logic                oor_q;
  logic                oor_now;

  // Lower edge of bin n: min + n*width, product taken unsigned.
  function automatic acc_t thresh(input logic [BIN_BITS-1:0] n,
                                  input logic [15:0] w,
                                  input logic [15:0] m);
    logic [PW-1:0] prod;
    prod = PW'(n) * PW'(w);
    return acc_t'($signed(m)) + acc_t'(prod);
  endfunction

  assign val_ext = acc_t'($signed(val_i));
  assign oor_now = (val_ext < thresh('0, width_i, min_i)) ||
                   (val_ext >= thresh(bin_num_i, width_i, min_i));

  always_comb begin
    trial = cur_q | bit_q;
    cur_d = cur_q;
    if ((trial < bin_num_i) && (val_q >= thresh(trial, width_i, min_i)))
      cur_d = trial;
  end

  // bit_q is a one-hot marker of the bit under test; zero when idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      val_q <= '0;
      cur_q <= '0;
      bit_q <= '0;
      oor_q <= 1'b0;
    end else if (start_i) begin
      val_q <= val_ext;
      cur_q <= '0;
      bit_q <= BIN_BITS'(1) << (BIN_BITS - 1);
      oor_q <= oor_now;
    end else if (bit_q != '0) begin
      cur_q <= cur_d;
      bit_q <= bit_q >> 1;
    end
  end

  assign done_o = bit_q[0];
  assign oor_o  = oor_q;
  assign idx_o  = oor_q ? '1 : cur_q;

endmodule

// File: rtl/hist2d_accum.sv
// hist2d_accum: 2D I/Q histogram with stream and accumulate modes.
// Each accepted sample is binned on both axes; stream mode emits the bin
// coordinates, accumulate mode bumps a saturating counter in on-chip RAM
// and dump_req streams the whole histogram plus a final out-of-range word.
// Optional build macro HIST_CLEAR_ON_DUMP_EN: dump zeroes bins as they are
// accepted and resets the out-of-range count after the final word.
//   clk100, reset              clock, asynchronous active-high reset
//   data_in / data_ready       sample handshake
//   i_val, q_val               signed samples
//   i/q_bin_num, _bin_width,
//   i/q_min, stream_mode       configuration, latched on clear / reset release
//   clear, dump_req            command pulses, honoured only in IDLE
//   out_valid / out_ready      output handshake
//   out_i_bin, out_q_bin       coordinates (all-ones = out of range)
//   out_count                  bin count (1 in stream mode)
//   busy                       controller not in IDLE
//   overflow                   sticky counter saturation flag
module hist2d_accum
  import hist_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BIN_BITS = 6,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic                clk100,
  input  logic                reset,
  input  logic                data_in,
  output logic                data_ready,
  input  logic [DATA_W-1:0]   i_val,
  input  logic [DATA_W-1:0]   q_val,
  input  logic [BIN_BITS-1:0] i_bin_num,
  input  logic [BIN_BITS-1:0] q_bin_num,
  input  logic [15:0]         i_bin_width,
  input  logic [15:0]         q_bin_width,
  input  logic [15:0]         i_min,
  input  logic [15:0]         q_min,
  input  logic                stream_mode,
  input  logic                clear,
  input  logic                dump_req,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIN_BITS-1:0] out_i_bin,
  output logic [BIN_BITS-1:0] out_q_bin,
  output logic [COUNT_W-1:0]  out_count,
  output logic                busy,
  output logic                overflow
);

  localparam int unsigned AW    = 2 * BIN_BITS;
  localparam int unsigned DEPTH = hist_ram_depth(BIN_BITS);

  hist_state_e         state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                oor_word_q, oor_word_d;
  logic [COUNT_W-1:0]  oor_cnt_q, oor_cnt_d;
  logic                ovf_q, ovf_d;
  logic                cfg_pend_q;
  logic                cfg_load;

  logic [BIN_BITS-1:0] i_num_q, q_num_q;
  logic [15:0]         i_width_q, q_width_q, i_min_q, q_min_q;
  logic                stream_q;

  logic                search_start;
  logic                i_done, q_done, i_oor, q_oor;
  logic [BIN_BITS-1:0] i_idx, q_idx;
  logic [AW-1:0]       bin_addr;
  logic [BIN_BITS-1:0] dump_i, dump_q;
  logic                last_bin;

  logic [COUNT_W-1:0]  mem [DEPTH];
  logic [COUNT_W-1:0]  rd_q;
  logic                we;
  logic [AW-1:0]       waddr, raddr;
  logic [COUNT_W-1:0]  wdata;

  axis_bin_search #(.DATA_W(DATA_W), .BIN_BITS(BIN_BITS)) u_i_search (
    .clk_i     (clk100),
    .rst_i     (reset),
    .start_i   (search_start),
    .val_i     (i_val),
    .bin_num_i (i_num_q),
    .width_i   (i_width_q),
    .min_i     (i_min_q),
    .done_o    (i_done),
    .idx_o     (i_idx),
    .oor_o     (i_oor)
  );

  axis_bin_search #(.DATA_W(DATA_W), .BIN_BITS(BIN_BITS)) u_q_search (
    .clk_i     (clk100),
    .rst_i     (reset),
    .start_i   (search_start),
    .val_i     (q_val),
    .bin_num_i (q_num_q),
    .width_i   (q_width_q),
    .min_i     (q_min_q),
    .done_o    (q_done),
    .idx_o     (q_idx),
    .oor_o     (q_oor)
  );

  assign bin_addr = {i_idx, q_idx};
  assign dump_i   = addr_q[AW-1:BIN_BITS];
  assign dump_q   = addr_q[BIN_BITS-1:0];
  assign last_bin = (dump_i == i_num_q - BIN_BITS'(1)) &&
                    (dump_q == q_num_q - BIN_BITS'(1));

  always_ff @(posedge clk100) begin
    if (we) mem[waddr] <= wdata;
    rd_q <= mem[raddr];
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    oor_word_d   = oor_word_q;
    oor_cnt_d    = oor_cnt_q;
    ovf_d        = ovf_q;
    cfg_load     = cfg_pend_q;
    search_start = 1'b0;
    we           = 1'b0;
    waddr        = addr_q;
    wdata        = '0;
    raddr        = addr_q;
    data_ready   = 1'b0;
    out_valid    = 1'b0;
    out_i_bin    = '0;
    out_q_bin    = '0;
    out_count    = '0;
    busy         = 1'b1;

    case (state_q)
      CLEAR: begin
        we        = 1'b1;
        oor_cnt_d = '0;
        addr_d    = addr_q + AW'(1);
        if (addr_q == '1) state_d = IDLE;
      end

      IDLE: begin
        busy = 1'b0;
        // data_ready is withheld whenever a command takes priority so a
        // coincident sample is never handshaken.
        if (clear) begin
          state_d  = CLEAR;
          cfg_load = 1'b1;
          addr_d   = '0;
        end else if (dump_req && !stream_q) begin
          state_d    = DUMP_RD;
          addr_d     = '0;
          oor_word_d = 1'b0;
        end else begin
          data_ready = 1'b1;
          if (data_in) begin
            search_start = 1'b1;
            state_d      = SEARCH;
          end
        end
      end

      SEARCH: begin
        if (i_done && q_done) begin
          if (stream_q) begin
            state_d = OUT_STREAM;
          end else if (i_oor || q_oor) begin
            if (oor_cnt_q != '1) oor_cnt_d = oor_cnt_q + COUNT_W'(1);
            state_d = IDLE;
          end else begin
            state_d = ACCUM_RD;
          end
        end
      end

      OUT_STREAM: begin
        out_valid = 1'b1;
        out_i_bin = i_idx;
        out_q_bin = q_idx;
        out_count = COUNT_W'(1);
        if (out_ready) state_d = IDLE;
      end

      ACCUM_RD: begin
        raddr   = bin_addr;
        state_d = ACCUM_WR;
      end

      ACCUM_WR: begin
        we    = 1'b1;
        waddr = bin_addr;
        if (rd_q == '1) begin
          wdata = rd_q;
          ovf_d = 1'b1;
        end else begin
          wdata = rd_q + COUNT_W'(1);
        end
        state_d = IDLE;
      end

      DUMP_RD: state_d = DUMP_OUT;

      DUMP_OUT: begin
        out_valid = 1'b1;
        if (oor_word_q) begin
          out_i_bin = '1;
          out_q_bin = '1;
          out_count = oor_cnt_q;
          if (out_ready) begin
            state_d = IDLE;
`ifdef HIST_CLEAR_ON_DUMP_EN
            oor_cnt_d = '0;
`endif
          end
        end else begin
          out_i_bin = dump_i;
          out_q_bin = dump_q;
          out_count = rd_q;
          if (out_ready) begin
`ifdef HIST_CLEAR_ON_DUMP_EN
            we = 1'b1;
`endif
            // The out-of-range word needs no RAM read, so stay here.
            if (last_bin) begin
              oor_word_d = 1'b1;
            end else begin
              state_d = DUMP_RD;
              if (dump_q == q_num_q - BIN_BITS'(1))
                addr_d = {dump_i + BIN_BITS'(1), BIN_BITS'(0)};
              else
                addr_d = addr_q + AW'(1);
            end
          end
        end
      end

      default: state_d = CLEAR;
    endcase
  end

  // cfg_pend_q captures the configuration on the first edge after reset.
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR;
      addr_q     <= '0;
      oor_word_q <= 1'b0;
      oor_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      cfg_pend_q <= 1'b1;
      i_num_q    <= '0;
      q_num_q    <= '0;
      i_width_q  <= '0;
      q_width_q  <= '0;
      i_min_q    <= '0;
      q_min_q    <= '0;
      stream_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      oor_word_q <= oor_word_d;
      oor_cnt_q  <= oor_cnt_d;
      ovf_q      <= ovf_d;
      cfg_pend_q <= 1'b0;
      if (cfg_load) begin
        i_num_q   <= i_bin_num;
        q_num_q   <= q_bin_num;
        i_width_q <= i_bin_width;
        q_width_q <= q_bin_width;
        i_min_q   <= i_min;
        q_min_q   <= q_min;
        stream_q  <= stream_mode;
      end
    end
  end

  assign overflow = ovf_q;

endmodule

// File: tb/tb_hist2d_accum.sv
// tb_hist2d_accum: directed bench for hist2d_accum. Two instances share all
// inputs: dut_a uses 16-bit counters, dut_b 4-bit counters for saturation.
module tb_hist2d_accum;

  localparam int BB = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_in, clear, dump_req, out_ready, stream_mode;
  logic [31:0] i_val, q_val;
  logic [BB-1:0] i_bin_num, q_bin_num;
  logic [15:0] i_bin_width, q_bin_width, i_min, q_min;

  logic          a_data_ready, a_out_valid, a_busy, a_overflow;
  logic [BB-1:0] a_out_i_bin, a_out_q_bin;
  logic [15:0]   a_out_count;
  logic          b_data_ready, b_out_valid, b_busy, b_overflow;
  logic [BB-1:0] b_out_i_bin, b_out_q_bin;
  logic [3:0]    b_out_count;

  int n_vec  = 0;
  int n_miss = 0;
  int n;

  always #5 clk = ~clk;

  hist2d_accum #(.DATA_W(32), .BIN_BITS(BB), .COUNT_W(16)) dut_a (
    .clk100(clk), .reset(reset), .data_in(data_in), .data_ready(a_data_ready),
    .i_val(i_val), .q_val(q_val), .i_bin_num(i_bin_num), .q_bin_num(q_bin_num),
    .i_bin_width(i_bin_width), .q_bin_width(q_bin_width), .i_min(i_min), .q_min(q_min),
    .stream_mode(stream_mode), .clear(clear), .dump_req(dump_req),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_i_bin(a_out_i_bin),
    .out_q_bin(a_out_q_bin), .out_count(a_out_count), .busy(a_busy), .overflow(a_overflow)
  );

  hist2d_accum #(.DATA_W(32), .BIN_BITS(BB), .COUNT_W(4)) dut_b (
    .clk100(clk), .reset(reset), .data_in(data_in), .data_ready(b_data_ready),
    .i_val(i_val), .q_val(q_val), .i_bin_num(i_bin_num), .q_bin_num(q_bin_num),
    .i_bin_width(i_bin_width), .q_bin_width(q_bin_width), .i_min(i_min), .q_min(q_min),
    .stream_mode(stream_mode), .clear(clear), .dump_req(dump_req),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_i_bin(b_out_i_bin),
    .out_q_bin(b_out_q_bin), .out_count(b_out_count), .busy(b_busy), .overflow(b_overflow)
  );

  task automatic check_eq(input string tag, input longint unsigned got,
                          input longint unsigned want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Count negedges until dut_a reports data_ready, bounded by limit.
  task automatic wait_ready(input int limit, output int cnt);
    cnt = 0;
    while (!a_data_ready && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic wait_valid(input int limit, output int cnt);
    cnt = 0;
    while (!a_out_valid && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  // Presents one sample for a single edge; returns in the cycle after acceptance.
  task automatic send(input int iv, input int qv);
    i_val   = iv;
    q_val   = qv;
    data_in = 1'b1;
    @(negedge clk);
    data_in = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Dump with out_ready toggling every cycle; checks the 4x4 grid in order
  // followed by the out-of-range word.
  task automatic do_dump(input string tag, input int hot_i, input int hot_q,
                         input int hot_a, input int hot_b, input int oor);
    int nw, cyc, ei, eq, ea, eb;
    logic tog;
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    nw = 0; cyc = 0; tog = 1'b0;
    while (nw < 17 && cyc < 200) begin
      tog       = ~tog;
      out_ready = tog;
      if (a_out_valid && out_ready) begin
        if (nw < 16) begin
          ei = nw / 4;
          eq = nw % 4;
          ea = (ei == hot_i && eq == hot_q) ? hot_a : 0;
          eb = (ei == hot_i && eq == hot_q) ? hot_b : 0;
        end else begin
          ei = 63; eq = 63; ea = oor; eb = oor;
        end
        check_eq({tag, "_i"},   a_out_i_bin, ei);
        check_eq({tag, "_q"},   a_out_q_bin, eq);
        check_eq({tag, "_cnt"}, a_out_count, ea);
        check_eq({tag, "_cnt_b"}, b_out_count, eb);
        nw++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check_eq({tag, "_words"}, nw, 17);
    check_eq({tag, "_idle"}, a_busy, 0);
  endtask

  int sv_i[6]  = '{-20, -11, -10, 19, 20, -21};
  int sv_q[6]  = '{5, -20, 19, 0, -1, -10};
  int sv_ei[6] = '{0, 0, 1, 3, 63, 63};
  int sv_eq[6] = '{2, 0, 3, 2, 1, 1};

  initial begin
    reset = 1'b1; data_in = 1'b0; clear = 1'b0; dump_req = 1'b0; out_ready = 1'b0;
    i_val = '0; q_val = '0;
    i_bin_num = 6'd4; q_bin_num = 6'd4;
    i_bin_width = 16'd10; q_bin_width = 16'd10;
    i_min = 16'hFFEC; q_min = 16'hFFEC;   // -20
    stream_mode = 1'b1;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", a_busy, 1);
    check_eq("rst_ready", a_data_ready, 0);
    check_eq("rst_valid", a_out_valid, 0);
    check_eq("rst_ovf", a_overflow, 0);
    check_eq("rst_out_i", a_out_i_bin, 0);
    check_eq("rst_out_cnt", a_out_count, 0);
    reset = 1'b0;
    wait_ready(5000, n);
    check_eq("init_clear_len", n, 4096);

    // Stream mode: coordinates and latency N+BIN_BITS+1.
    for (int v = 0; v < 6; v++) begin
      send(sv_i[v], sv_q[v]);
      wait_valid(40, n);
      check_eq("str_lat", n + 1, BB + 1);
      check_eq("str_i", a_out_i_bin, sv_ei[v]);
      check_eq("str_q", a_out_q_bin, sv_eq[v]);
      check_eq("str_cnt", a_out_count, 1);
      repeat (2) @(negedge clk);
      check_eq("str_hold", a_out_valid, 1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq("str_ready", a_data_ready, 1);
    end

    // clear + dump_req + data_in together: clear wins, switches to accumulate.
    stream_mode = 1'b0;
    i_val = 5; q_val = -15;
    data_in = 1'b1; clear = 1'b1; dump_req = 1'b1;
    #1;
    check_eq("prio_ready", a_data_ready, 0);
    @(negedge clk);
    data_in = 1'b0; clear = 1'b0; dump_req = 1'b0;
    check_eq("prio_busy", a_busy, 1);
    wait_ready(5000, n);
    check_eq("prio_clear_len", n, 4096);

    // Accumulate: 5 in-range samples to bin (2,0) plus 2 out-of-range.
    for (int k = 0; k < 5; k++) begin
      send(5, -15);
      wait_ready(40, n);
      check_eq("acc_lat", n + 1, BB + 3);
    end
    send(30, 0);
    wait_ready(40, n);
    check_eq("oor_lat_i", n + 1, BB + 1);
    send(0, -25);
    wait_ready(40, n);
    check_eq("oor_lat_q", n + 1, BB + 1);
    do_dump("dump1", 2, 0, 5, 5, 2);
    do_dump("dump2", 2, 0, 5, 5, 2);

    // Saturation: dut_b holds at 15 and flags overflow, dut_a keeps counting.
    pulse_clear();
    wait_ready(5000, n);
    for (int k = 0; k < 17; k++) begin
      send(5, -15);
      wait_ready(40, n);
    end
    check_eq("sat_ovf_a", a_overflow, 0);
    check_eq("sat_ovf_b", b_overflow, 1);
    do_dump("sat", 2, 0, 17, 15, 0);
    check_eq("sat_ovf_sticky", b_overflow, 1);

    // Reset during DUMP_OUT aborts the dump and restarts the clear sweep.
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    wait_valid(40, n);
    check_eq("rd_valid_pre", a_out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("rd_valid_async", a_out_valid, 0);
    check_eq("rd_busy", a_busy, 1);
    check_eq("rd_ovf_b", b_overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_ready(5000, n);
    check_eq("rd_clear_len", n, 4096);
    do_dump("zero", -1, -1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hist2d_accum.md
Name: hist2d_accum

Overview:
- Parametrised successor to the fixed 6-bit 2D histogram path.
- Takes I/Q samples and bins each axis with a fixed-latency successive-approximation search.
- Stream mode: emits bin coordinates per sample.
- Accumulate mode: keeps per-bin counts in on-chip RAM and dumps the full histogram on request.
- Sits between the I/Q demodulator and the host output mux of the analysis FSM.

Parameters:
DATA_W, 32, signed I/Q sample width
BIN_BITS, 6, bin index width; max bins per axis 2^BIN_BITS-1; index all-ones = out of range (OOR)
COUNT_W, 16, per-bin counter width

Ports:
clk100  in  1  system clock
reset  in  1  asynchronous, active-high reset
data_in  in  1  sample valid
data_ready  out  1  sample accepted when data_in && data_ready
i_val, q_val  in  DATA_W  signed samples
i_bin_num, q_bin_num  in  BIN_BITS  bins per axis, 1..2^BIN_BITS-1
i_bin_width, q_bin_width  in  16  unsigned bin width, nonzero
i_min, q_min  in  16  signed origin of bin 0
stream_mode  in  1  1 = stream coordinates, 0 = accumulate
clear  in  1  pulse: latch config, zero RAM and OOR count
dump_req  in  1  pulse: stream histogram out
out_valid  out  1  output word valid; held until out_ready
out_ready  in  1  downstream accept
out_i_bin, out_q_bin  out  BIN_BITS  coordinates
out_count  out  COUNT_W  bin count (1 in stream mode)
busy  out  1  FSM not in IDLE
overflow  out  1  sticky: a counter saturated

Behaviour:
- Config (bin_num, width, min, stream_mode) is latched on clear and at reset release. Inputs are ignored otherwise.
- Reset values: state=CLEAR, addr=0, data_ready=0, out_valid=0, out_* =0, busy=1, overflow=0, oor_count=0. Reset mid-operation aborts everything and restarts the CLEAR sweep.
- States and transitions:
  - CLEAR: writes 0 to addresses 0..2^(2*BIN_BITS)-1, one per cycle, then goes to IDLE.
  - IDLE: data_ready=1, busy=0. Priority: clear > dump_req > data_in. clear goes to CLEAR. dump_req goes to DUMP_RD (ignored if stream_mode). Accepted sample is latched and goes to SEARCH.
  - SEARCH: BIN_BITS cycles, MSB to LSB. trial=cur|(1<<k). Set the bit iff trial<bin_num and v >= min+trial*width. Arithmetic is signed, DATA_W+BIN_BITS+2 bits wide; min is sign-extended; the product is unsigned BIN_BITS+16 bits, zero-extended.
  - OOR rule: v<min or v >= min+bin_num*width gives an all-ones index for that axis. A value exactly on a boundary goes to the upper bin.
  - Exit from SEARCH: stream_mode goes to OUT_STREAM; otherwise, if either axis is OOR, oor_count++ (saturating) and return to IDLE, else ACCUM_RD.
  - OUT_STREAM: out_valid=1, coords driven, out_count=1. Returns to IDLE on out_ready.
  - ACCUM_RD: issues RAM read at {i_bin,q_bin}. RAM has 1-cycle read latency.
  - ACCUM_WR: writes count+1. If count is all-ones, writes it unchanged and sets overflow. Returns to IDLE.
  - DUMP_RD / DUMP_OUT: i outer, q inner, over 0..bin_num-1 on each axis. Each word is held until out_ready, then the next address is read. After the last bin, one extra word is sent with coords all-ones and out_count=oor_count. Then IDLE.
- Latency: sample accepted at cycle N gives out_valid at N+BIN_BITS+1 (stream mode). In accumulate mode, data_ready returns at N+BIN_BITS+3.
- Only one sample is in flight; no RAM read-modify-write hazard exists.
- clear or dump_req while busy is ignored. A dump does not alter counts unless the optional feature is enabled.
- Counters and oor_count saturate; they never wrap.

Optional Feature:
- HIST_CLEAR_ON_DUMP_EN defined: DUMP_OUT writes 0 to each bin as its word is accepted, and oor_count resets after the final word. The histogram is empty after a dump.
- Undefined: a dump is non-destructive and counts persist until clear.

Decomposition:
- Package hist_pkg holds:
  - state enum (CLEAR, IDLE, SEARCH, OUT_STREAM, ACCUM_RD, ACCUM_WR, DUMP_RD, DUMP_OUT);
  - OOR index constant;
  - RAM depth constant 2^(2*BIN_BITS).
- Sub-module axis_bin_search, instantiated twice (I, Q). Each is a start/done, fixed BIN_BITS-cycle searcher outputting index plus oor flag.
- RAM is inferred inline.

Test Plan:
- Config bin_num=4, width=10, min=-20, stream mode. Samples i=-20, -11, -10, 19 give i_bin 0, 0, 1, 3 with out_valid at N+BIN_BITS+1.
- Same config. i=20 and i=-21 give i_bin=63 (all-ones). q in range yields its normal bin.
- Accumulate mode, 5 samples at (i=5, q=-15) plus 2 OOR, then dump. 16 words are sent, with bin (2,0)=5 and all others 0, followed by the OOR word (63,63,2). out_ready is toggled every other cycle and no word may be lost.
- Saturation with COUNT_W=4: 17 identical samples give count=15 and overflow=1 (sticky until reset).
- Reset asserted mid-DUMP_OUT: out_valid drops asynchronously, busy stays high for 4096 cycles (CLEAR), and a subsequent dump gives all zeros.
- data_in, clear and dump_req asserted together in IDLE: clear wins, the sample is not accepted, and data_ready stays 0 until CLEAR completes.
